// File: rtl/operand_sequencer_pkg.sv
// Shared types and constants for the UART add-path operand sequencer.
`timescale 1ns/1ps
package operand_sequencer_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        SEND    = 1'b1
    } seq_state_t;

    localparam int DEFAULT_WIDTH          = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1200000;
    localparam int MIN_OPS                = 2;
    localparam int MAX_OPS                = 4;

    // Width of the slot index that drives the N_OPS-wide one-hot OP_SEL.
    function automatic int idx_width(input int n_ops);
        return (n_ops <= 2) ? 1 : $clog2(n_ops);
    endfunction

endpackage

// File: rtl/operand_sequencer_idle_timer.sv
// Clearable saturating up-counter with a terminal-count pulse; LIMIT=0 disables it.
`timescale 1ns/1ps
module idle_timer #(
    parameter int LIMIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || (LIMIT == 0)) begin
            count <= '0;
        end else if (enable && (count != CW'(LIMIT))) begin
            count <= count + CW'(1);
        end
    end

    // A clear in the limit cycle wins over expiry.
    assign expired = (LIMIT != 0) && enable && !clear && (count == CW'(LIMIT));

endmodule

// File: rtl/operand_sequencer.sv
// Steers received bytes into operand slots, sums them with sticky carry and hands
// the result to the UART transmitter.
//   state   | meaning
//   COLLECT | accepting operands into slot idx; inter-byte timer armed when idx>0
//   SEND    | result complete, waiting for TX_READY; incoming bytes are dropped
`timescale 1ns/1ps
module operand_sequencer
    import operand_sequencer_pkg::*;
#(
    parameter int WIDTH          = DEFAULT_WIDTH,
    parameter int N_OPS          = 2,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic             CLKIN,
    input  logic             RESET,
    input  logic             RX_VALID,
    input  logic [WIDTH-1:0] RX_BYTE,
    input  logic             TX_READY,
    output logic             TX_START,
    output logic [WIDTH-1:0] TX_BYTE,
    output logic             CARRY,
    output logic [N_OPS-1:0] OP_SEL,
    output logic             BUSY,
    output logic             TIMEOUT_ERR,
    output logic             DROPPED
);

    localparam int             IW       = idx_width(N_OPS);
    localparam logic [IW-1:0]  LAST_IDX = IW'(N_OPS - 1);
    localparam logic [N_OPS-1:0] SLOT0  = {{(N_OPS-1){1'b0}}, 1'b1};

    seq_state_t       state, state_nxt;
    logic [IW-1:0]    idx, idx_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic             cflag, cflag_nxt;
    logic [WIDTH-1:0] tx_byte_nxt;
    logic             carry_nxt, tx_start_nxt, timeout_nxt, dropped_nxt;
    logic [WIDTH:0]   sum;
    logic             timer_clear, timer_enable, timer_expired;

    assign timer_enable = (state == COLLECT) && (idx != '0);
    assign timer_clear  = RX_VALID || (state == SEND) || (idx == '0);

    idle_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk    (CLKIN),
        .rst    (RESET),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(timer_expired)
    );

    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            state       <= COLLECT;
            idx         <= '0;
            acc         <= '0;
            cflag       <= 1'b0;
            TX_BYTE     <= '0;
            CARRY       <= 1'b0;
            TX_START    <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
            DROPPED     <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            acc         <= acc_nxt;
            cflag       <= cflag_nxt;
            TX_BYTE     <= tx_byte_nxt;
            CARRY       <= carry_nxt;
            TX_START    <= tx_start_nxt;
            TIMEOUT_ERR <= timeout_nxt;
            DROPPED     <= dropped_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        acc_nxt      = acc;
        cflag_nxt    = cflag;
        tx_byte_nxt  = TX_BYTE;
        carry_nxt    = CARRY;
        tx_start_nxt = 1'b0;
        timeout_nxt  = 1'b0;
        dropped_nxt  = 1'b0;
        sum          = {1'b0, acc} + {1'b0, RX_BYTE};
        case (state)
            COLLECT: begin
                // The launch cycle still belongs to the previous result.
                if (RX_VALID && TX_START) begin
                    dropped_nxt = 1'b1;
                end else if (RX_VALID) begin
                    if (idx == '0) begin
                        acc_nxt   = RX_BYTE;
                        cflag_nxt = 1'b0;
                    end else begin
                        acc_nxt   = sum[WIDTH-1:0];
                        cflag_nxt = cflag | sum[WIDTH];
                    end
                    if (idx == LAST_IDX) begin
                        state_nxt = SEND;
                    end else begin
                        idx_nxt = idx + IW'(1);
                    end
                end else if (timer_expired) begin
                    idx_nxt     = '0;
                    acc_nxt     = '0;
                    timeout_nxt = 1'b1;
                end
            end
            SEND: begin
                dropped_nxt = RX_VALID;
                if (TX_READY) begin
                    tx_byte_nxt  = acc;
                    carry_nxt    = cflag;
                    tx_start_nxt = 1'b1;
                    state_nxt    = COLLECT;
                    idx_nxt      = '0;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    assign OP_SEL = SLOT0 << idx;
    assign BUSY   = (state == SEND) || (idx != '0);

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed-vector bench for operand_sequencer: a 2-operand and a 3-operand instance,
// both with a 10-cycle inter-byte timeout.
`timescale 1ns/1ps
module tb_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid, tx_ready, tx_start, carry, busy, timeout_err, dropped;
    logic [7:0] rx_byte, tx_byte;
    logic [1:0] op_sel;
    logic       rx_valid3, tx_ready3, tx_start3, carry3, busy3, timeout_err3, dropped3;
    logic [7:0] rx_byte3, tx_byte3;
    logic [2:0] op_sel3;

    int n_vec = 0, n_miss = 0;
    int n_start = 0, n_tmo = 0, n_drop = 0;
    int s0, d0, t0, lat;

    always #5 clk = ~clk;

    operand_sequencer #(.WIDTH(8), .N_OPS(2), .TIMEOUT_CYCLES(10)) dut2 (
        .CLKIN(clk), .RESET(rst), .RX_VALID(rx_valid), .RX_BYTE(rx_byte),
        .TX_READY(tx_ready), .TX_START(tx_start), .TX_BYTE(tx_byte), .CARRY(carry),
        .OP_SEL(op_sel), .BUSY(busy), .TIMEOUT_ERR(timeout_err), .DROPPED(dropped)
    );

    operand_sequencer #(.WIDTH(8), .N_OPS(3), .TIMEOUT_CYCLES(10)) dut3 (
        .CLKIN(clk), .RESET(rst), .RX_VALID(rx_valid3), .RX_BYTE(rx_byte3),
        .TX_READY(tx_ready3), .TX_START(tx_start3), .TX_BYTE(tx_byte3), .CARRY(carry3),
        .OP_SEL(op_sel3), .BUSY(busy3), .TIMEOUT_ERR(timeout_err3), .DROPPED(dropped3)
    );

    // Pulse counters, sampled shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (tx_start)    n_start++;
        if (timeout_err) n_tmo++;
        if (dropped)     n_drop++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send3(input logic [7:0] b);
        rx_byte3  = b;
        rx_valid3 = 1'b1;
        @(negedge clk);
        rx_valid3 = 1'b0;
    endtask

    task automatic wait_start(output int cycles);
        cycles = 0;
        while (!tx_start && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        if (!tx_start) chk("tx_start_seen", 32'd0, 32'd1);
    endtask

    task automatic pair(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_sum, input logic exp_c);
        int l;
        send(a);
        send(b);
        wait_start(l);
        chk({tag, "_sum"}, tx_byte, exp_sum);
        chk({tag, "_carry"}, carry, exp_c);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_byte = '0; tx_ready = 1'b1;
        rx_valid3 = 1'b0; rx_byte3 = '0; tx_ready3 = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_carry", carry, 0);
        chk("rst_op_sel", op_sel, 2'b01);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_dropped", dropped, 0);
        chk("rst_op_sel3", op_sel3, 3'b001);
        rst = 1'b0;
        @(negedge clk);

        // Basic add with slot sequencing and launch latency
        send(8'h12);
        chk("basic_op_sel1", op_sel, 2'b10);
        chk("basic_busy", busy, 1);
        send(8'h34);
        chk("basic_op_sel_send", op_sel, 2'b10);
        chk("basic_no_early_start", tx_start, 0);
        wait_start(lat);
        chk("basic_latency", lat, 1);
        chk("basic_sum", tx_byte, 8'h46);
        chk("basic_carry", carry, 0);
        chk("basic_op_sel_back", op_sel, 2'b01);
        @(negedge clk);
        chk("basic_start_pulse", tx_start, 0);
        chk("basic_hold", tx_byte, 8'h46);

        pair("ovf", 8'hF0, 8'h20, 8'h10, 1'b1);
        pair("carry_clear", 8'h01, 8'h02, 8'h03, 1'b0);

        // Three operands, sticky carry
        send3(8'h80);
        chk("n3_op_sel1", op_sel3, 3'b010);
        send3(8'h80);
        chk("n3_op_sel2", op_sel3, 3'b100);
        send3(8'h01);
        lat = 0;
        while (!tx_start3 && lat < 200) begin @(negedge clk); lat++; end
        chk("n3_latency", lat, 1);
        chk("n3_sum", tx_byte3, 8'h01);
        chk("n3_carry", carry3, 1);
        @(negedge clk);
        send3(8'h01); send3(8'h02); send3(8'h03);
        lat = 0;
        while (!tx_start3 && lat < 200) begin @(negedge clk); lat++; end
        chk("n3b_sum", tx_byte3, 8'h06);
        chk("n3b_carry", carry3, 0);
        @(negedge clk);

        // Backpressure with a dropped byte
        tx_ready = 1'b0;
        send(8'hAA);
        send(8'h11);
        s0 = n_start; d0 = n_drop; t0 = n_tmo;
        repeat (10) @(negedge clk);
        send(8'h55);
        repeat (39) @(negedge clk);
        chk("bp_no_start", n_start - s0, 0);
        chk("bp_drop_count", n_drop - d0, 1);
        chk("bp_busy", busy, 1);
        chk("bp_op_sel", op_sel, 2'b10);
        tx_ready = 1'b1;
        wait_start(lat);
        chk("bp_sum", tx_byte, 8'hBB);
        chk("bp_carry", carry, 0);
        chk("bp_no_timeout", n_tmo - t0, 0);
        @(negedge clk);

        // Inter-byte timeout
        t0 = n_tmo;
        send(8'h07);
        lat = 0;
        while (!timeout_err && lat < 30) begin @(negedge clk); lat++; end
        chk("tmo_latency", lat, 11);
        chk("tmo_op_sel", op_sel, 2'b01);
        chk("tmo_busy", busy, 0);
        chk("tmo_count", n_tmo - t0, 1);
        @(negedge clk);
        chk("tmo_pulse_width", timeout_err, 0);
        pair("after_tmo", 8'h01, 8'h02, 8'h03, 1'b0);

        // Byte arrives in the expiry cycle
        t0 = n_tmo;
        send(8'h20);
        repeat (10) @(negedge clk);
        send(8'h05);
        wait_start(lat);
        chk("race_sum", tx_byte, 8'h25);
        chk("race_no_timeout", n_tmo - t0, 0);
        @(negedge clk);

        // Byte during the TX_START cycle is dropped
        send(8'h30);
        send(8'h01);
        wait_start(lat);
        chk("txs_sum", tx_byte, 8'h31);
        d0 = n_drop;
        send(8'h99);
        chk("txs_dropped", n_drop - d0, 1);
        chk("txs_op_sel", op_sel, 2'b01);
        pair("after_txs", 8'h03, 8'h04, 8'h07, 1'b0);

        // Reset between operands
        send(8'h40);
        chk("rstmid_busy_pre", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_op_sel", op_sel, 2'b01);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_tx_byte", tx_byte, 0);
        @(negedge clk);
        rst = 1'b0;
        s0 = n_start;
        repeat (5) @(negedge clk);
        chk("rstmid_no_start", n_start - s0, 0);
        pair("after_rstmid", 8'h05, 8'h06, 8'h0B, 1'b0);

        // Reset while waiting in SEND
        pair("pre_rstsend", 8'hFF, 8'hFF, 8'hFE, 1'b1);
        tx_ready = 1'b0;
        send(8'h10);
        send(8'h10);
        chk("rstsend_busy_pre", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("rstsend_busy", busy, 0);
        chk("rstsend_op_sel", op_sel, 2'b01);
        chk("rstsend_tx_byte", tx_byte, 0);
        chk("rstsend_carry", carry, 0);
        @(negedge clk);
        rst = 1'b0;
        tx_ready = 1'b1;
        s0 = n_start;
        repeat (5) @(negedge clk);
        chk("rstsend_no_start", n_start - s0, 0);
        pair("after_rstsend", 8'h21, 8'h22, 8'h43, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/operand_sequencer.md
# operand_sequencer

Controller that sequences the UART add path: it steers successive received bytes into operand slots, accumulates them into a modulo-2^WIDTH sum with sticky carry, and hands the finished result to the UART transmitter with a start/ready handshake. It sits between the receiver byte strobe and the `transmit` block. It replaces the free-running slot counter and decoder with a controlled FSM that has an inter-byte timeout and defined drop behaviour.

## Interface
- `WIDTH`, 8: operand and result width in bits.
- `N_OPS`, 2: operands per result, legal range 2..4.
- `TIMEOUT_CYCLES`, 1200000: maximum idle cycles between operands of one result (100 ms at 12 MHz); 0 disables the timeout.

- `CLKIN` in 1: single clock; all state is on its rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `RX_VALID` in 1: one-cycle strobe, `RX_BYTE` is valid.
- `RX_BYTE` in WIDTH: received operand.
- `TX_READY` in 1: transmitter idle and able to accept a byte.
- `TX_START` out 1: one-cycle pulse that launches a transmission.
- `TX_BYTE` out WIDTH: result; held stable from `TX_START` until the next `TX_START`.
- `CARRY` out 1: sticky carry of the result in `TX_BYTE`, updated with it.
- `OP_SEL` out N_OPS: one-hot index of the slot being filled; drives per-receiver CE.
- `BUSY` out 1: high while a partial or pending result exists.
- `TIMEOUT_ERR` out 1: one-cycle pulse when a partial result is discarded.
- `DROPPED` out 1: one-cycle pulse when an `RX_VALID` byte is ignored.

## Operation
- Reset values: `TX_START`=0, `TX_BYTE`=0, `CARRY`=0, `OP_SEL`=1 (slot 0), `BUSY`=0, `TIMEOUT_ERR`=0, `DROPPED`=0. State is COLLECT, idx=0, acc=0, carry flag=0, timer=0.
- The FSM has two states, COLLECT and SEND.
- COLLECT behaviour on `RX_VALID`:
  - idx=0: acc←`RX_BYTE`, cflag←0.
  - idx>0: {c, acc}←acc+`RX_BYTE`, cflag←cflag|c.
  - In both cases the timer clears. If idx=N_OPS-1 the FSM goes to SEND; otherwise idx increments.
- `OP_SEL` = 1<<idx in COLLECT. It holds the last slot in SEND.
- Timeout: in COLLECT with idx>0, the timer counts cycles with no `RX_VALID`. When it reaches `TIMEOUT_CYCLES`, idx←0, acc is discarded, and `TIMEOUT_ERR` pulses. While idx=0 the timer stays at 0.
- SEND: on the first cycle with `TX_READY`=1, the block registers `TX_BYTE`←acc and `CARRY`←cflag, pulses `TX_START` on the next cycle, and returns to COLLECT with idx=0.
- `RX_VALID` in SEND, including the `TX_START` cycle, is dropped: no state change, and `DROPPED` pulses.
- `BUSY` = (state==SEND) | (idx≠0).
- Arithmetic wraps modulo 2^WIDTH. The carry is the OR of every carry-out generated within one result.

## Timing
- Final operand strobe at cycle t → SEND at t+1. The earliest `TX_START` is at t+2 (when `TX_READY`=1 at t+1). `TX_BYTE`/`CARRY` change in the same cycle `TX_START` rises.
- If `TX_READY`=0, the block waits indefinitely. There is no timeout in SEND.
- `RX_VALID` in the same cycle the timer reaches its limit: the byte wins. It is accepted, the timer clears, and there is no `TIMEOUT_ERR`.
- `TIMEOUT_ERR` is asserted the cycle after the timer reaches `TIMEOUT_CYCLES`. Idx=0 is visible on `OP_SEL` in that same cycle.
- `RESET` mid-result or mid-SEND: all outputs return to their reset values immediately (asynchronously). No `TX_START` is emitted for the aborted result.
- Back-to-back results: the first operand of the next result is accepted from the cycle after `TX_START`.

## Structure
- Shared package holds:
  - the state enum (COLLECT, SEND);
  - default `WIDTH` and `TIMEOUT_CYCLES` constants;
  - the one-hot helper width rule (N_OPS).
- One sub-module, `idle_timer`: a clearable up-counter with a terminal-count pulse and a disable when the limit is 0. It is reusable for receiver framing timeouts.
- Accumulator, carry flag and FSM stay in `operand_sequencer`.

## Test plan
- Basic add: bytes 0x12, 0x34 with `TX_READY`=1 → `TX_START` 2 cycles after the second strobe; `TX_BYTE`=0x46, `CARRY`=0; `OP_SEL` sequence 01→10→01.
- Overflow: 0xF0 then 0x20 → `TX_BYTE`=0x10, `CARRY`=1. With N_OPS=3, bytes 0x80, 0x80, 0x01 → `TX_BYTE`=0x01, `CARRY`=1 (sticky).
- Backpressure: hold `TX_READY`=0 for 50 cycles after the second operand, and strobe a byte 0x55 meanwhile → `DROPPED` pulses once and there is no `TX_START`. Raise `TX_READY` → `TX_START` with the original sum, unaffected by 0x55.
- Timeout: `TIMEOUT_CYCLES`=10, one byte 0x07 then silence → `TIMEOUT_ERR` pulse 11 cycles later, `OP_SEL`=01. Next pair 0x01, 0x02 → `TX_BYTE`=0x03.
- Race: `RX_VALID` on the exact expiry cycle → no `TIMEOUT_ERR`; the result equals the sum of both bytes.
- Reset mid-operation: assert `RESET` between operand 1 and operand 2, or while in SEND → outputs return to reset values asynchronously, no `TX_START` follows, and the next pair produces a correct sum.
